conv3x3_stream_ctrl: RTL

CONV3X3_STREAM_CTRL -- requirements
Module: conv3x3_stream_ctrl

---
 rtl/conv3x3_stream_ctrl_pkg.sv | 13 +
 rtl/conv3x3_stream_ctrl_mac.sv | 18 +
 rtl/conv3x3_stream_ctrl.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/conv3x3_stream_ctrl_pkg.sv
// Shared constants for the 3x3 streaming convolution controller.
package conv3x3_stream_ctrl_pkg;

    localparam int PIX_W = 8;
    localparam int ACC_W = 16;
    localparam int KTAPS = 9;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

endpackage

// File: rtl/conv3x3_stream_ctrl_mac.sv
// Combinational nine-tap multiply-accumulate: 8x8 unsigned products, sum wraps mod 2^16.
module conv3x3_mac
    import conv3x3_stream_ctrl_pkg::*;
(
    input  logic [PIX_W*KTAPS-1:0] pixels,
    input  logic [PIX_W*KTAPS-1:0] kernel,
    output logic [ACC_W-1:0]       sum
);

    // Accumulate the nine products; carries out of bit 15 are dropped
    always_comb begin
        sum = '0;
        for (int unsigned i = 0; i < KTAPS; i++) begin
            sum = sum + (ACC_W'(pixels[i*PIX_W +: PIX_W]) * ACC_W'(kernel[i*PIX_W +: PIX_W]));
        end
    end

endmodule

// File: rtl/conv3x3_stream_ctrl.sv
// Streaming 3x3 valid-convolution controller with two line buffers and a
// one-entry output buffer.
module conv3x3_stream_ctrl
    import conv3x3_stream_ctrl_pkg::*;
#(
    parameter int IMG_W = 8,
    parameter int IMG_H = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [PIX_W*KTAPS-1:0] kernel,
    input  logic                   in_valid,
    input  logic [PIX_W-1:0]       in_pixel,
    output logic                   in_ready,
    output logic                   out_valid,
    output logic [ACC_W-1:0]       out_data,
    input  logic                   out_ready,
    output logic                   busy,
    output logic                   done
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    logic [1:0]             state;
    logic [PIX_W*KTAPS-1:0] kernel_q;
    logic [CW-1:0]          col;
    logic [RW-1:0]          row;
    logic [PIX_W-1:0]       lb1 [IMG_W];   // row r-1
    logic [PIX_W-1:0]       lb2 [IMG_W];   // row r-2
    logic [PIX_W-1:0]       win      [KTAPS];
    logic [PIX_W-1:0]       win_next [KTAPS];
    logic [PIX_W*KTAPS-1:0] win_flat;
    logic [ACC_W-1:0]       sum;
    logic                   accept;
    logic                   col_last;
    logic                   last_px;
    logic                   completes;

    assign in_ready  = (state == ST_RUN) && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;
    assign busy      = (state != ST_IDLE);
    assign col_last  = (col == CW'(IMG_W - 1));
    assign last_px   = col_last && (row == RW'(IMG_H - 1));
    assign completes = (row >= RW'(2)) && (col >= CW'(2));

    // Window after the incoming column is shifted in; the MAC sees this so
    // the result can be registered on the same edge that accepts the pixel.
    always_comb begin
        win_next[0] = win[1];
        win_next[1] = win[2];
        win_next[2] = lb2[col];
        win_next[3] = win[4];
        win_next[4] = win[5];
        win_next[5] = lb1[col];
        win_next[6] = win[7];
        win_next[7] = win[8];
        win_next[8] = in_pixel;
        win_flat    = '0;
        for (int unsigned i = 0; i < KTAPS; i++) begin
            win_flat[i*PIX_W +: PIX_W] = win_next[i];
        end
    end

    conv3x3_mac u_mac (
        .pixels (win_flat),
        .kernel (kernel_q),
        .sum    (sum)
    );

    // Line buffers: push the column down one row on every accepted pixel
    always_ff @(posedge clk) begin
        if (accept) begin
            lb2[col] <= lb1[col];
            lb1[col] <= in_pixel;
        end
    end

    // Window shift register advances only on accepted pixels
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < KTAPS; i++) win[i] <= '0;
        end else if (accept) begin
            for (int unsigned i = 0; i < KTAPS; i++) win[i] <= win_next[i];
        end
    end

    // Frame sequencing: kernel latch, raster counters, flush and done pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            kernel_q <= '0;
            col      <= '0;
            row      <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        kernel_q <= kernel;
                        col      <= '0;
                        row      <= '0;
                        state    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (accept) begin
                        if (col_last) begin
                            col <= '0;
                            row <= row + RW'(1);
                        end else begin
                            col <= col + CW'(1);
                        end
                        if (last_px) state <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    if (!out_valid) begin
                        done  <= 1'b1;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // One-entry output buffer; a completing pixel reloads it even while the
    // current result is being consumed, so there is no bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (accept && completes) begin
            out_valid <= 1'b1;
            out_data  <= sum;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
